// File: rtl/freq_div_ctrl_pkg.sv
// Shared state encoding and requester indices for the reference-clock divider.
package freq_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import freq_div_ctrl_pkg::*;
(
  input  logic       clk_ref,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_grant;  // 1: B was granted most recently

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[REQ_A] && req[REQ_B]) begin
        grant[REQ_A] = last_grant;
        grant[REQ_B] = ~last_grant;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant[REQ_B]) begin
      last_grant <= 1'b1;
    end else if (grant[REQ_A]) begin
      last_grant <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock divider; two requesters may update the half period,
// which only takes effect on a phase boundary.
// state     | meaning
// IDLE      | stopped, clk_div low, cnt held at 0
// RUN       | dividing clk_ref by 2*(half_cur+1)
// STOP_PEND | en dropped in the high phase; finish it, then IDLE
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 49
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] half_a,
  input  logic [CNT_W-1:0] half_b,
  output logic [1:0]       ack,
  output logic             clk_div,
  output logic             tick,
  output logic [CNT_W-1:0] half_cur,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_val;
  logic             pend_valid;
  logic             arb_en;
  logic             terminal;
  logic             apply;
  logic [1:0]       grant;

  // No arbitration while a value is pending or being acknowledged.
  assign arb_en   = ~pend_valid & (ack == 2'b00);
  assign terminal = (cnt == half_cur);
  assign apply    = pend_valid & ((state == ST_IDLE) | terminal);

  rr_arb2 u_arb (
    .clk_ref (clk_ref),
    .rst     (rst),
    .req     (req),
    .enable  (arb_en),
    .grant   (grant)
  );

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      clk_div    <= 1'b0;
      tick       <= 1'b0;
      ack        <= 2'b00;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      half_cur   <= CNT_W'(DEF_HALF);
    end else begin
      tick <= 1'b0;
      ack  <= grant;

      if (grant != 2'b00) begin
        pend_valid <= 1'b1;
        pend_val   <= grant[REQ_B] ? half_b : half_a;
      end else if (apply) begin
        pend_valid <= 1'b0;
        half_cur   <= pend_val;
      end

      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          clk_div <= 1'b0;
          if (en) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en && !clk_div) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (terminal) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
            tick    <= ~clk_div;
            if (!en) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (!en) state <= ST_STOP_PEND;
          end
        end
        ST_STOP_PEND: begin
          // clk_div is high here, so the terminal count always ends the run.
          if (terminal) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          clk_div <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: phase-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_freq_div_ctrl;

  localparam int CNT_W    = 16;
  localparam int DEF_HALF = 49;

  logic             clk_ref = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       req;
  logic [CNT_W-1:0] half_a;
  logic [CNT_W-1:0] half_b;
  logic [1:0]       ack;
  logic             clk_div;
  logic             tick;
  logic [CNT_W-1:0] half_cur;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase-level view (cycles left in phase, output level).
  bit       m_busy, m_stop, m_level, m_tick, m_pend, m_last_b;
  int       m_left, m_half, m_pval;
  logic [1:0] m_ack;

  int n, e, p, hc, tc;

  always #5 clk_ref = ~clk_ref;

  freq_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk_ref  (clk_ref),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .half_a   (half_a),
    .half_b   (half_b),
    .ack      (ack),
    .clk_div  (clk_div),
    .tick     (tick),
    .half_cur (half_cur),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_stop = 0; m_level = 0; m_tick = 0; m_pend = 0;
    m_last_b = 1; m_left = 0; m_half = DEF_HALF; m_pval = 0; m_ack = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] g;
    bit apply;
    int new_half;
    g = 2'b00;
    if (!m_pend && m_ack == 2'b00) begin
      if (req == 2'b11) g = m_last_b ? 2'b01 : 2'b10;
      else g = req;
    end
    apply    = m_pend && (!m_busy || m_left == 1);
    new_half = apply ? m_pval : m_half;
    m_tick   = 0;
    if (!m_busy) begin
      m_level = 0;
      if (en) begin
        m_busy = 1;
        m_left = new_half + 1;
      end
    end else if (!m_stop && !en && !m_level) begin
      m_busy = 0;
    end else if (m_left == 1) begin
      if (m_level && (m_stop || !en)) begin
        m_level = 0; m_busy = 0; m_stop = 0;
      end else begin
        m_level = !m_level;
        m_tick  = m_level;
        m_left  = new_half + 1;
      end
    end else begin
      m_left--;
      if (!en && m_level) m_stop = 1;
    end
    m_half = new_half;
    if (apply) m_pend = 0;
    if (g != 2'b00) begin
      m_pend   = 1;
      m_pval   = g[1] ? int'(half_b) : int'(half_a);
      m_last_b = g[1];
    end
    m_ack = g;
  endtask

  // One clock: advance model, compare every output, requesters drop on ack.
  task automatic step();
    @(posedge clk_ref);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("clk_div", 32'(clk_div), 32'(m_level));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("half_cur", 32'(half_cur), m_half);
    chk("busy", 32'(busy), 32'(m_busy));
    if (ack[0]) req[0] = 1'b0;
    if (ack[1]) req[1] = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int limit, output int cnt_o);
    cnt_o = 0;
    do begin step(); cnt_o++; end while (!tick && cnt_o < limit);
    chk(name, 32'(tick), 32'd1);
  endtask

  task automatic wait_ack(input string name, input int limit);
    int k;
    k = 0;
    do begin step(); k++; end while (ack == 2'b00 && k < limit);
    chk(name, 32'(ack != 2'b00), 32'd1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_half_cur", 32'(half_cur), 32'd49);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = 2'b00; half_a = '0; half_b = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    chk("init_clk_div", 32'(clk_div), 32'd0);
    chk("init_half_cur", 32'(half_cur), 32'd49);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_ack", 32'(ack), 32'd0);

    // Start with the default half period: first rise and full period.
    en = 1'b1;
    e = 0;
    do begin step(); e++; end while (!clk_div && e < 200);
    chk("first_rise_latency", e, 32'd51);
    wait_tick("period_100", 300, p);
    chk("period_100_len", p, 32'd100);

    // Update from A at the start of a high phase: phase finishes at old length.
    req = 2'b01; half_a = 16'd4;
    hc = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (clk_div) hc++;
      else break;
    end
    chk("high_phase_unchanged", hc, 32'd50);
    chk("half_cur_4", 32'(half_cur), 32'd4);
    wait_tick("tick_after_update", 50, p);
    wait_tick("period_10", 50, p);
    chk("period_10_len", p, 32'd10);

    // Drop en during a low phase: IDLE next cycle, no tick.
    n = 0;
    do begin step(); n++; end while (clk_div && n < 50);
    chk("reached_low", 32'(clk_div), 32'd0);
    en = 1'b0;
    step();
    chk("low_stop_busy", 32'(busy), 32'd0);
    tc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      tc += int'(tick) + int'(clk_div);
    end
    chk("low_stop_quiet", tc, 32'd0);

    // Back to 49, drop en three cycles into the high phase.
    req = 2'b01; half_a = 16'd49;
    wait_ack("ack_49", 10);
    step();
    en = 1'b1;
    wait_tick("tick_49", 200, p);
    step();
    step();
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (clk_div) n++;
      else break;
    end
    chk("high_tail_47", n, 32'd47);
    chk("high_stop_busy", 32'(busy), 32'd0);

    // Reset in the high phase with a pending update from B.
    en = 1'b1;
    wait_tick("tick_pre_rst", 200, p);
    step();
    req = 2'b10; half_b = 16'd7;
    wait_ack("ack_b_pre_rst", 10);
    step();
    en = 1'b0;
    async_reset();

    // Both request from IDLE: A first, then B one cycle after A is applied.
    req = 2'b11; half_a = 16'd9; half_b = 16'd0;
    wait_ack("ack_tie", 10);
    chk("tie_winner_a", 32'(ack), 32'd1);
    step();
    chk("idle_apply_9", 32'(half_cur), 32'd9);
    chk("idle_apply_busy", 32'(busy), 32'd0);
    step();
    chk("second_winner_b", 32'(ack), 32'd2);
    step();
    chk("idle_apply_0", 32'(half_cur), 32'd0);
    en = 1'b1;
    wait_tick("tick_half0", 20, p);
    wait_tick("period_2", 20, p);
    chk("period_2_len", p, 32'd2);

    // All-ones half period is accepted and holds the low phase.
    en = 1'b0;
    repeat (3) step();
    req = 2'b01; half_a = 16'hFFFF;
    wait_ack("ack_max", 10);
    step();
    chk("half_cur_max", 32'(half_cur), 32'd65535);
    en = 1'b1;
    repeat (20) step();
    chk("max_still_low", 32'(clk_div), 32'd0);
    en = 1'b0;
    step();
    chk("max_stop_busy", 32'(busy), 32'd0);
    req = 2'b01; half_a = 16'd3;
    wait_ack("ack_3", 10);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if (!req[0] && $urandom_range(0, 15) == 0) begin
        half_a = CNT_W'($urandom_range(0, 5));
        req[0] = 1'b1;
      end
      if (!req[1] && $urandom_range(0, 15) == 0) begin
        half_b = CNT_W'($urandom_range(0, 5));
        req[1] = 1'b1;
      end
      if (i == 2000) async_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the counter and half-period width.
REQ-002 The block SHALL have parameter DEF_HALF, default 49, giving the half-period minus one loaded at reset (divide-by-100).
REQ-003 clk_ref  input  1  Sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 en  input  1  Run request for the divided clock.
REQ-006 req  input  2  Per-requester half-period update request; req[0] is A, req[1] is B.
REQ-007 half_a  input  CNT_W  Half-period minus one offered by requester A.
REQ-008 half_b  input  CNT_W  Half-period minus one offered by requester B.
REQ-009 ack  output  2  One-cycle registered grant pulse per requester.
REQ-010 clk_div  output  1  Registered divided clock.
REQ-011 tick  output  1  Registered one-cycle pulse, high in the cycle clk_div goes 0->1.
REQ-012 half_cur  output  CNT_W  Half-period value currently in force.
REQ-013 busy  output  1  High when the state is not IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and STOP_PEND.
REQ-015 In IDLE the block SHALL hold cnt=0 and clk_div=0, and SHALL move to RUN on the cycle after en=1 is sampled.
REQ-016 In RUN and STOP_PEND, cnt==half_cur SHALL be the terminal count; at terminal count cnt SHALL clear to 0 and clk_div SHALL toggle, and otherwise cnt SHALL increment by 1.
REQ-017 In RUN with en=0 and clk_div=0, the next state SHALL be IDLE with cnt cleared, and no partial low phase SHALL be extended.
REQ-018 In RUN with en=0 and clk_div=1, the next state SHALL be STOP_PEND; the high phase SHALL complete to terminal count, then clk_div SHALL go to 0 and the state to IDLE.
REQ-019 In STOP_PEND, en=1 SHALL be ignored until IDLE is reached, and a new start SHALL be taken from IDLE.
REQ-020 Arbitration SHALL occur only in cycles where pend_valid=0 and ack==2'b00.
REQ-021 Among asserted req bits, the arbiter SHALL pick round-robin, giving priority to the requester not granted last; a single requester SHALL win outright.
REQ-022 On a grant, the next cycle SHALL have the winner's ack bit at 1, pend_val loaded with the winner's half value sampled at the arbitration cycle, and pend_valid set to 1.
REQ-023 Requesters SHALL hold req and data until ack; req seen in the ack cycle SHALL be ignored.
REQ-024 A pending value SHALL be applied to half_cur at the next terminal count in RUN/STOP_PEND, or on the next cycle in IDLE, and pend_valid SHALL clear then.
REQ-025 The apply and the next arbitration SHALL NOT occur in the same cycle; arbitration SHALL resume the cycle after pend_valid clears.
REQ-026 half value 0 SHALL be legal and give clk_div toggling every cycle (period 2); all-ones SHALL be the maximum, and cnt SHALL never exceed half_cur.
REQ-027 A new half_cur SHALL take effect from the first phase after the terminal count that applied it, and the current phase SHALL never be truncated.

Reset
REQ-028 While rst=1, the block SHALL immediately force state=IDLE, cnt=0, clk_div=0, tick=0, ack=0, busy=0, pend_valid=0, pend_val=0, half_cur=DEF_HALF, and last_grant=B (so A wins first).
REQ-029 Reset asserted mid-phase or with a pending update SHALL discard the pending value, and the ack of a discarded update SHALL NOT be reissued.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE, RUN, STOP_PEND, 2 bits) and the requester index constants (REQ_A=0, REQ_B=1).
REQ-031 The round-robin arbiter SHALL be one sub-module, rr_arb2: inputs clk_ref, rst, req[1:0], enable; output grant[1:0]; it SHALL hold last_grant internally.
REQ-032 The counter, FSM and pending register SHALL reside in freq_div_ctrl.

Verification
REQ-033 Reset then en=1 with DEF_HALF=49 -> clk_div rises 51 cycles after en sampled, and the period SHALL be 100 cycles with tick once per period.
REQ-034 In RUN, req A with half_a=4 -> ack[0] high one cycle; the current phase completes unchanged, then the period SHALL be 10 cycles and half_cur=4.
REQ-035 req=2'b11 held from IDLE, half_a=9, half_b=0 -> ack[0] first, half_cur=9 in IDLE; then ack[1] one cycle after pend clears, half_cur=0 and period 2 once running.
REQ-036 en dropped 3 cycles into the high phase with half=49 -> clk_div stays high 47 more cycles, falls, busy=0, and IDLE is entered.
REQ-037 rst pulsed mid high phase with an update pending -> outputs return to reset values in the same cycle, half_cur=49, no ack, and the next arbitration grants A.
REQ-038 en dropped while clk_div=0 -> IDLE on the next cycle, clk_div=0 throughout, and no tick.
